alu_mc: RTL and testbench

- Parametrised multi-cycle ALU for the RISC-V datapath, succeeding the single-cycle combinational ALU.
- Keeps the existing six 4-bit op codes bit-for-bit and adds SRA, SLT, SLTU and XOR.
- Adds iterative MUL, MULHU, DIVU and REMU.
- Operands and results move over valid/ready handshakes, so the multi-cycle pipeline and a stalling single-cycle core can both use it.

---
 rtl/alu_mc_if.sv | 28 ++
 rtl/alu_mc.sv | 155 +++++++++++++++
 tb/tb_alu_mc.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for the multi-cycle ALU.
// No latency of its own: wires only.
// Producer holds in_valid until in_ready; consumer drives out_ready to drain alu_result.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic             busy;

    // Producer/consumer side of the ALU
    modport master (
        output in_valid, alu_op, data1, data2, out_ready,
        input  in_ready, out_valid, alu_result, busy
    );

    // ALU side
    modport slave (
        input  in_valid, alu_op, data1, data2, out_ready,
        output in_ready, out_valid, alu_result, busy
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative MUL, MULHU, DIVU, REMU.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for iterative ops (accept to out_valid).
// Backpressure: result held in DONE until out_ready; no new op accepted until back in IDLE.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = SHW + 1;

    localparam logic [3:0] OP_SLL   = 4'b0000;
    localparam logic [3:0] OP_MUL   = 4'b0001;
    localparam logic [3:0] OP_SRL   = 4'b0010;
    localparam logic [3:0] OP_SRA   = 4'b0011;
    localparam logic [3:0] OP_SLT   = 4'b0100;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_MULHU = 4'b0110;
    localparam logic [3:0] OP_DIVU  = 4'b0111;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_REMU  = 4'b1001;
    localparam logic [3:0] OP_SUB   = 4'b1010;
    localparam logic [3:0] OP_AND   = 4'b1100;
    localparam logic [3:0] OP_OR    = 4'b1101;
    localparam logic [3:0] OP_XOR   = 4'b1110;

    logic [1:0]         state_q,  state_d;
    logic [3:0]         op_q,     op_d;
    logic [WIDTH-1:0]   opnd_q,   opnd_d;   // multiplicand (MUL*) or divisor (DIV/REM)
    logic [2*WIDTH-1:0] prod_q,   prod_d;   // {hi, lo}: product, or {remainder, quotient}
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_rem;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;

    function automatic logic [WIDTH-1:0] single_op(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return $unsigned($signed(a) >>> sh);
            OP_SLT:  return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: return {{(WIDTH-1){1'b0}}, (a < b)};
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return '0;
        endcase
    endfunction

    function automatic logic is_iter(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

    // One radix-2 step: shift-add multiply or restoring shift-subtract divide
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
        div_rem   = prod_q[2*WIDTH-1:WIDTH-1];
        div_ge    = div_rem >= {1'b0, opnd_q};
        div_diff  = div_rem[WIDTH-1:0] - opnd_q;
        div_next  = div_ge ? {div_diff, prod_q[WIDTH-2:0], 1'b1}
                           : {div_rem[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
        step_next = is_mul(op_q) ? mul_next : div_next;
    end

    // Next-state and datapath control for IDLE/BUSY/DONE
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d = bus.alu_op;
                    if (is_iter(bus.alu_op)) begin
                        // MUL*: add data1 while consuming data2 bits; DIV/REM: shift data1 in, subtract data2
                        opnd_d  = is_mul(bus.alu_op) ? bus.data1 : bus.data2;
                        prod_d  = {{WIDTH{1'b0}}, (is_mul(bus.alu_op) ? bus.data2 : bus.data1)};
                        cnt_d   = CW'(WIDTH);
                        state_d = S_BUSY;
                    end else begin
                        result_d = single_op(bus.alu_op, bus.data1, bus.data2);
                        state_d  = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                prod_d = step_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    // High half holds MULHU product / REMU remainder; low half MUL product / DIVU quotient
                    result_d = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? step_next[2*WIDTH-1:WIDTH]
                                                                          : step_next[WIDTH-1:0];
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            opnd_q   <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.busy       = (state_q == S_BUSY);
    assign bus.alu_result = result_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH 8, 32 and 64 against an arithmetic reference model.
// Checks result, accept-to-valid latency, busy duration, backpressure and async reset.
// Inputs driven #1 after the rising edge; outputs sampled at the same point.
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(8))  if8  ();
    alu_mc_if #(.WIDTH(32)) if32 ();
    alu_mc_if #(.WIDTH(64)) if64 ();

    alu_mc #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    alu_mc #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
    alu_mc #(.WIDTH(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(if64.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_in(input int w, input logic v, input logic [3:0] op,
                            input logic [63:0] a, input logic [63:0] b);
        case (w)
            8:  begin if8.in_valid  = v; if8.alu_op  = op; if8.data1  = a[7:0];  if8.data2  = b[7:0];  end
            32: begin if32.in_valid = v; if32.alu_op = op; if32.data1 = a[31:0]; if32.data2 = b[31:0]; end
            default: begin if64.in_valid = v; if64.alu_op = op; if64.data1 = a; if64.data2 = b; end
        endcase
    endtask

    task automatic set_ordy(input int w, input logic r);
        case (w)
            8:  if8.out_ready  = r;
            32: if32.out_ready = r;
            default: if64.out_ready = r;
        endcase
    endtask

    function automatic logic [63:0] get_res(input int w);
        case (w)
            8:  return {56'b0, if8.alu_result};
            32: return {32'b0, if32.alu_result};
            default: return if64.alu_result;
        endcase
    endfunction

    function automatic logic get_ov(input int w);
        case (w)
            8:  return if8.out_valid;
            32: return if32.out_valid;
            default: return if64.out_valid;
        endcase
    endfunction

    function automatic logic get_ir(input int w);
        case (w)
            8:  return if8.in_ready;
            32: return if32.in_ready;
            default: return if64.in_ready;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            8:  return if8.busy;
            32: return if32.busy;
            default: return if64.busy;
        endcase
    endfunction

    function automatic logic model_iter(input logic [3:0] op);
        return op == 4'b0001 || op == 4'b0110 || op == 4'b0111 || op == 4'b1001;
    endfunction

    // Reference: plain arithmetic on 64/128-bit values, masked to the width under test
    function automatic logic [63:0] model(input int w, input logic [3:0] op,
                                          input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0]  m, a, b, sa, sb, r;
        logic [127:0] p;
        int           sh;
        m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        a  = a_in & m;
        b  = b_in & m;
        sh = int'(b % 64'(w));
        sa = a[w-1] ? (a | ~m) : a;
        sb = b[w-1] ? (b | ~m) : b;
        p  = {64'b0, a} * {64'b0, b};
        case (op)
            4'b0000: r = a << sh;
            4'b0010: r = a >> sh;
            4'b0011: r = $unsigned($signed(sa) >>> sh);
            4'b0100: r = {63'b0, ($signed(sa) < $signed(sb))};
            4'b0101: r = {63'b0, (a < b)};
            4'b1000: r = a + b;
            4'b1010: r = a - b;
            4'b1100: r = a & b;
            4'b1101: r = a | b;
            4'b1110: r = a ^ b;
            4'b0001: r = p[63:0];
            4'b0110: r = 64'(p >> w);
            4'b0111: r = (b == 0) ? m : a / b;
            4'b1001: r = (b == 0) ? a : a % b;
            default: r = 64'b0;
        endcase
        return r & m;
    endfunction

    // Issue one op, scramble inputs after accept, check latency, busy span and result, then drain
    task automatic run_op(input int w, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input string tag);
        logic [63:0] exp;
        int          lat, nb, exp_lat;
        exp     = model(w, op, a, b);
        exp_lat = model_iter(op) ? w + 1 : 1;
        drive_in(w, 1'b1, op, a, b);
        chk({tag, "_in_ready"}, 64'(get_ir(w)), 64'd1);
        @(posedge clk); #1;
        drive_in(w, 1'b0, 4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom});
        lat = 1;
        nb  = 0;
        while (!get_ov(w) && lat < w + 20) begin
            if (get_busy(w)) nb++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(nb), model_iter(op) ? 64'(w) : 64'd0);
        chk({tag, "_result"}, get_res(w), exp);
        set_ordy(w, 1'b1);
        @(posedge clk); #1;
        set_ordy(w, 1'b0);
        chk({tag, "_out_valid_drop"}, 64'(get_ov(w)), 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        int          ws[2];
        drive_in(8, 1'b0, 4'b0, 64'b0, 64'b0);
        drive_in(32, 1'b0, 4'b0, 64'b0, 64'b0);
        drive_in(64, 1'b0, 4'b0, 64'b0, 64'b0);
        set_ordy(8, 1'b0);
        set_ordy(32, 1'b0);
        set_ordy(64, 1'b0);

        // Reset state
        #12;
        chk("rst_in_ready", 64'(if32.in_ready), 64'd1);
        chk("rst_out_valid", 64'(if32.out_valid), 64'd0);
        chk("rst_busy", 64'(if32.busy), 64'd0);
        chk("rst_result", get_res(32), 64'd0);
        chk("rst_result8", get_res(8), 64'd0);
        chk("rst_result64", get_res(64), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed set at WIDTH=32
        run_op(32, 4'b1000, 64'h7FFF_FFFF, 64'h1, "add_ovf");
        run_op(32, 4'b1010, 64'd5, 64'd7, "sub_neg");
        run_op(32, 4'b0000, 64'd1, 64'd35, "sll_mask");
        run_op(32, 4'b0010, 64'h8000_0000, 64'd36, "srl");
        run_op(32, 4'b0011, 64'h8000_0000, 64'd4, "sra");
        run_op(32, 4'b0100, 64'hFFFF_FFFF, 64'd1, "slt");
        run_op(32, 4'b0101, 64'hFFFF_FFFF, 64'd1, "sltu");
        run_op(32, 4'b1100, 64'hF0F0_1234, 64'h0FF0_FFFF, "and");
        run_op(32, 4'b1101, 64'hF0F0_1234, 64'h0FF0_FFFF, "or");
        run_op(32, 4'b1110, 64'hF0F0_1234, 64'h0FF0_FFFF, "xor");
        run_op(32, 4'b1111, 64'h1234, 64'h5678, "undef");
        run_op(32, 4'b0001, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "mul");
        run_op(32, 4'b0110, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "mulhu");
        run_op(32, 4'b0111, 64'd100, 64'd7, "divu");
        run_op(32, 4'b1001, 64'd100, 64'd7, "remu");
        run_op(32, 4'b0111, 64'd5, 64'd0, "divu_z");
        run_op(32, 4'b1001, 64'd5, 64'd0, "remu_z");

        // Backpressure: result held, next op waits until after the output handshake
        drive_in(32, 1'b1, 4'b1000, 64'd10, 64'd20);
        @(posedge clk); #1;
        drive_in(32, 1'b1, 4'b1010, 64'd9, 64'd4);
        chk("bp_first_valid", 64'(if32.out_valid), 64'd1);
        held = get_res(32);
        chk("bp_first_result", held, 64'd30);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_result", get_res(32), 64'd30);
            chk("bp_hold_in_ready", 64'(if32.in_ready), 64'd0);
        end
        set_ordy(32, 1'b1);
        @(posedge clk); #1;
        set_ordy(32, 1'b0);
        chk("bp_after_hs_out_valid", 64'(if32.out_valid), 64'd0);
        chk("bp_after_hs_in_ready", 64'(if32.in_ready), 64'd1);
        @(posedge clk); #1;
        drive_in(32, 1'b0, 4'b0, 64'b0, 64'b0);
        chk("bp_second_valid", 64'(if32.out_valid), 64'd1);
        chk("bp_second_result", get_res(32), model(32, 4'b1010, 64'd9, 64'd4));
        set_ordy(32, 1'b1);
        @(posedge clk); #1;
        set_ordy(32, 1'b0);

        // Reset in the middle of a divide
        drive_in(32, 1'b1, 4'b0111, 64'd1000, 64'd3);
        @(posedge clk); #1;
        drive_in(32, 1'b0, 4'b0, 64'b0, 64'b0);
        repeat (9) @(posedge clk);
        #1;
        chk("mid_busy", 64'(if32.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(if32.in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(if32.out_valid), 64'd0);
        chk("mid_rst_busy", 64'(if32.busy), 64'd0);
        chk("mid_rst_result", get_res(32), 64'd0);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_discarded", 64'(if32.out_valid), 64'd0);
        run_op(32, 4'b1000, 64'd2, 64'd3, "add_after_rst");

        // Single-cycle set at WIDTH=8 and WIDTH=64 (shift masking 3 and 6 bits)
        ws[0] = 8;
        ws[1] = 64;
        foreach (ws[k]) begin
            run_op(ws[k], 4'b1000, (64'd1 << (ws[k] - 1)) - 64'd1, 64'd1, "w_add");
            run_op(ws[k], 4'b1010, 64'd5, 64'd7, "w_sub");
            run_op(ws[k], 4'b0000, 64'd1, 64'd35, "w_sll");
            run_op(ws[k], 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd77, "w_srl");
            run_op(ws[k], 4'b0011, 64'd1 << (ws[k] - 1), 64'd4, "w_sra");
            run_op(ws[k], 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "w_slt");
            run_op(ws[k], 4'b0101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "w_sltu");
            run_op(ws[k], 4'b1110, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0F0F_0F0F_0F0F_0F0F, "w_xor");
            run_op(ws[k], 4'b1111, 64'd3, 64'd4, "w_undef");
        end

        // Randomised ops across all widths and all codes
        for (int i = 0; i < 40; i++) begin
            logic [63:0] ra, rb;
            int          w;
            w  = (i % 3 == 0) ? 8 : ((i % 3 == 1) ? 32 : 64);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rb = rb & 64'hF;
            run_op(w, 4'($urandom_range(0, 15)), ra, rb, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
